// File: rtl/pixel_triplet_packer.sv
// Packs a serial row-major pixel stream into 3-lane beats with frame markers and latched mode.
// Latency: a beat is valid the cycle after its third (or the frame's last) pixel transfers.
// Backpressure: in_ready = !out_valid || out_ready; a stalled beat freezes the accumulator.
module pixel_triplet_packer #(
    parameter int IMG_DIM    = 20,
    parameter int BIT_LENGTH = 5,
    parameter int LANES      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_LENGTH-1:0] in_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_LENGTH-1:0] pixel_out0,
    output logic [BIT_LENGTH-1:0] pixel_out1,
    output logic [BIT_LENGTH-1:0] pixel_out2,
    output logic [2:0]            lane_mask,
    output logic                  frame_start,
    output logic                  frame_last,
    output logic                  mode
);

    localparam int              TOTAL    = IMG_DIM * IMG_DIM;
    localparam int              PIX_W    = $clog2(TOTAL);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(TOTAL - 1);
    localparam logic [1:0]      LANE_END = 2'(LANES - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                  state, state_nxt;
    logic [PIX_W-1:0]        pix_cnt;
    logic [1:0]              lane_cnt;
    logic [BIT_LENGTH-1:0]   acc0, acc1;
    logic                    mode_q;

    logic                    accept;
    logic                    last_pix;
    logic                    emit;
    logic                    latch_mode;
    logic                    beat_mode;
    logic                    beat_start;
    logic [BIT_LENGTH-1:0]   beat0, beat1, beat2;
    logic [2:0]              beat_mask;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign last_pix = (pix_cnt == LAST_PIX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        emit       = 1'b0;
        latch_mode = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    latch_mode = 1'b1;
                    emit       = last_pix;
                    state_nxt  = last_pix ? IDLE : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    emit = (lane_cnt == LANE_END) || last_pix;
                    if (last_pix) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat assembly: the incoming pixel lands in lane lane_cnt, lanes above it are zero.
    always_comb begin
        beat0     = acc0;
        beat1     = '0;
        beat2     = '0;
        beat_mask = 3'b001;
        case (lane_cnt)
            2'd0: begin
                beat0     = in_pixel;
                beat_mask = 3'b001;
            end
            2'd1: begin
                beat1     = in_pixel;
                beat_mask = 3'b011;
            end
            default: begin
                beat1     = acc1;
                beat2     = in_pixel;
                beat_mask = 3'b111;
            end
        endcase
        beat_mode  = (state == IDLE) ? mode_in : mode_q;
        beat_start = (pix_cnt == PIX_W'(lane_cnt));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt  <= '0;
            lane_cnt <= '0;
            acc0     <= '0;
            acc1     <= '0;
            mode_q   <= 1'b0;
        end else if (accept) begin
            pix_cnt  <= last_pix ? '0 : pix_cnt + PIX_W'(1);
            lane_cnt <= emit ? 2'd0 : lane_cnt + 2'd1;
            if (latch_mode) begin
                mode_q <= mode_in;
            end
            if (!emit && lane_cnt == 2'd0) begin
                acc0 <= in_pixel;
            end
            if (!emit && lane_cnt == 2'd1) begin
                acc1 <= in_pixel;
            end
        end
    end

    // Output register holds the beat until it transfers; a same-cycle completion reloads it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            pixel_out0  <= '0;
            pixel_out1  <= '0;
            pixel_out2  <= '0;
            lane_mask   <= '0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            mode        <= 1'b0;
        end else if (emit) begin
            out_valid   <= 1'b1;
            pixel_out0  <= beat0;
            pixel_out1  <= beat1;
            pixel_out2  <= beat2;
            lane_mask   <= beat_mask;
            frame_start <= beat_start;
            frame_last  <= last_pix;
            mode        <= beat_mode;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_triplet_packer.sv
// Randomised and directed bench for pixel_triplet_packer: a queue-based frame model predicts every beat.
module tb_pixel_triplet_packer;

    localparam int IMG_DIM = 20;
    localparam int BL      = 5;
    localparam int TOTAL   = IMG_DIM * IMG_DIM;
    localparam int REC     = 300;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode_in;
    logic          in_valid;
    logic          in_ready;
    logic [BL-1:0] in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [BL-1:0] pixel_out0, pixel_out1, pixel_out2;
    logic [2:0]    lane_mask;
    logic          frame_start, frame_last, mode;

    pixel_triplet_packer #(.IMG_DIM(IMG_DIM), .BIT_LENGTH(BL), .LANES(3)) dut (
        .clk(clk), .reset(reset), .mode_in(mode_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready),
        .pixel_out0(pixel_out0), .pixel_out1(pixel_out1), .pixel_out2(pixel_out2),
        .lane_mask(lane_mask), .frame_start(frame_start), .frame_last(frame_last), .mode(mode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: every accepted pixel tagged with its frame index and the frame's mode.
    typedef struct {
        logic [BL-1:0] v;
        int            idx;
        logic          m;
    } pix_t;
    pix_t pq[$];
    int   m_idx = 0;
    logic m_mode = 1'b0;

    int beat_cnt = 0, start_cnt = 0, last_cnt = 0;
    int rec_l0[REC], rec_l1[REC], rec_l2[REC], rec_mask[REC], rec_start[REC], rec_last[REC], rec_mode[REC];

    int bn, bbase;
    int be[3];
    bit or_rand = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                pq.delete();
                m_idx = 0;
            end else begin
                chk("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
                if (in_valid && in_ready) begin
                    if (m_idx == 0) m_mode = mode_in;
                    pq.push_back(pix_t'{v: in_pixel, idx: m_idx, m: m_mode});
                    m_idx = (m_idx == TOTAL - 1) ? 0 : m_idx + 1;
                end
                if (out_valid) begin
                    chk("beat_has_pixels", (pq.size() > 0) ? 1 : 0, 1);
                    if (pq.size() > 0) begin
                        bbase = pq[0].idx;
                        bn = TOTAL - bbase;
                        if (bn > 3) bn = 3;
                        chk("beat_pixels_queued", (pq.size() >= bn) ? 1 : 0, 1);
                        for (int k = 0; k < 3; k++)
                            be[k] = (k < bn && k < pq.size()) ? int'(pq[k].v) : 0;
                        chk("lane0", pixel_out0, be[0]);
                        chk("lane1", pixel_out1, be[1]);
                        chk("lane2", pixel_out2, be[2]);
                        chk("lane_mask", lane_mask, (1 << bn) - 1);
                        chk("frame_start", frame_start, (bbase == 0) ? 1 : 0);
                        chk("frame_last", frame_last, (bbase + bn == TOTAL) ? 1 : 0);
                        chk("mode", mode, int'(pq[0].m));
                        if (out_ready) begin
                            if (beat_cnt < REC) begin
                                rec_l0[beat_cnt]    = pixel_out0;
                                rec_l1[beat_cnt]    = pixel_out1;
                                rec_l2[beat_cnt]    = pixel_out2;
                                rec_mask[beat_cnt]  = lane_mask;
                                rec_start[beat_cnt] = frame_start;
                                rec_last[beat_cnt]  = frame_last;
                                rec_mode[beat_cnt]  = mode;
                            end
                            beat_cnt++;
                            start_cnt += int'(frame_start);
                            last_cnt  += int'(frame_last);
                            for (int k = 0; k < bn; k++)
                                if (pq.size() > 0) void'(pq.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (or_rand) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // mpol: 0 = mode 0, 1 = mode 1, 2 = toggle per pixel, 3 = random
    task automatic send_frame(input int n, input int off, input int mpol, input bit rv, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int g;
            if (rv) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_pixel = rnd ? BL'($urandom) : BL'((i + off) % 32);
            case (mpol)
                0:       mode_in = 1'b0;
                1:       mode_in = 1'b1;
                2:       mode_in = i[0];
                default: mode_in = ($urandom_range(0, 1) == 1);
            endcase
            g = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                g++;
                if (g > 1000) begin
                    chk("in_ready_timeout", g, 0);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        or_rand  = 0;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        chk("drained_out_valid", out_valid, 0);
        chk("drained_model_queue", pq.size(), 0);
    endtask

    task automatic clear_stats();
        beat_cnt  = 0;
        start_cnt = 0;
        last_cnt  = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_p0"}, pixel_out0, 0);
        chk({tag, "_p1"}, pixel_out1, 0);
        chk({tag, "_p2"}, pixel_out2, 0);
        chk({tag, "_mask"}, lane_mask, 0);
        chk({tag, "_start"}, frame_start, 0);
        chk({tag, "_last"}, frame_last, 0);
        chk({tag, "_mode"}, mode, 0);
    endtask

    task automatic chk_beat(input string nm, input int b, input int a0, input int a1, input int a2);
        chk({nm, "_l0"}, rec_l0[b], a0);
        chk({nm, "_l1"}, rec_l1[b], a1);
        chk({nm, "_l2"}, rec_l2[b], a2);
    endtask

    int c0;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = '0;
        mode_in   = 1'b0;
        out_ready = 1'b1;
        #2;
        check_zero("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Full frame, no stalls
        clear_stats();
        c0 = cyc;
        send_frame(TOTAL, 0, 1, 0, 0);
        chk("t1_input_cycles", cyc - c0, TOTAL);
        drain();
        chk("t1_beats", beat_cnt, 134);
        chk_beat("t1_beat0", 0, 0, 1, 2);
        chk("t1_beat0_start", rec_start[0], 1);
        chk("t1_beat0_mode", rec_mode[0], 1);
        chk_beat("t1_beat133", 133, 15, 0, 0);
        chk("t1_beat133_mask", rec_mask[133], 1);
        chk("t1_beat133_last", rec_last[133], 1);
        chk("t1_beat132_mask", rec_mask[132], 7);

        // Consumer stall while beat 10 is presented
        clear_stats();
        fork
            send_frame(TOTAL, 0, 1, 0, 0);
            begin
                int g;
                g = 0;
                do begin
                    @(posedge clk);
                    #1;
                    g++;
                end while (!(out_valid && beat_cnt == 10) && g < 2000);
                chk("t2_beat10_seen", (g < 2000) ? 1 : 0, 1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("t2_stall_in_ready", in_ready, 0);
                    chk("t2_stall_valid", out_valid, 1);
                    chk("t2_stall_p0", pixel_out0, 30);
                    chk("t2_stall_p1", pixel_out1, 31);
                    chk("t2_stall_p2", pixel_out2, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t2_beats", beat_cnt, 134);
        chk_beat("t2_beat10", 10, 30, 31, 0);
        chk_beat("t2_beat11", 11, 1, 2, 3);

        // mode_in toggling after pixel 0
        clear_stats();
        send_frame(TOTAL, 0, 2, 0, 0);
        drain();
        chk("t3_beats", beat_cnt, 134);
        for (int b = 0; b < 134; b++) chk("t3_mode", rec_mode[b], 0);

        // Asynchronous reset mid-frame, then a fresh frame
        clear_stats();
        send_frame(201, 0, 1, 0, 0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_stats();
        send_frame(TOTAL, 5, 0, 0, 0);
        drain();
        chk("t4_beats", beat_cnt, 134);
        chk("t4_starts", start_cnt, 1);
        chk("t4_lasts", last_cnt, 1);
        chk("t4_beat0_start", rec_start[0], 1);
        chk_beat("t4_beat0", 0, 5, 6, 7);

        // Back-to-back frames
        clear_stats();
        send_frame(TOTAL, 0, 0, 0, 0);
        send_frame(TOTAL, 7, 1, 0, 0);
        drain();
        chk("t5_beats", beat_cnt, 268);
        chk("t5_starts", start_cnt, 2);
        chk("t5_lasts", last_cnt, 2);
        chk("t5_beat133_last", rec_last[133], 1);
        chk("t5_beat133_mask", rec_mask[133], 1);
        chk_beat("t5_beat134", 134, 7, 8, 9);
        chk("t5_beat134_start", rec_start[134], 1);
        chk("t5_beat134_mode", rec_mode[134], 1);
        chk("t5_beat0_mode", rec_mode[0], 0);

        // Random valid/ready, random pixels and modes
        clear_stats();
        or_rand = 1;
        send_frame(TOTAL, 0, 3, 1, 1);
        send_frame(TOTAL, 0, 3, 1, 1);
        drain();
        chk("t6_beats", beat_cnt, 268);
        chk("t6_starts", start_cnt, 2);
        chk("t6_lasts", last_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
